// File: rtl/vai_reset_seq.sv
// Per-sub-AFU reset sequencer: block new requests, drain outstanding traffic, hold reset, release.
// Define VAI_RESET_SEQ_TIMEOUT_EN to bound DRAIN by DRAIN_TIMEOUT and expose sticky timeout flags.

module vai_reset_seq_lane #(
   parameter int CNT_W         = 10,
   parameter int RESET_CYCLES  = 16,
   parameter int DRAIN_TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic trig_i,
   input  logic issue_i,
   input  logic done_i,
   output logic block_o,
   output logic rst_out_o,
   output logic timeout_o
);
   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_HOLD, S_DONE} state_e;

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              block_q, block_d;
   logic              rsto_q, rsto_d;
   logic              tmo_hit, tmo_set, tmo_clr;

`ifdef VAI_RESET_SEQ_TIMEOUT_EN
   localparam int DRN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);

   logic [DRN_W-1:0] drn_q, drn_d;
   logic             tmo_q, tmo_d;

   assign tmo_hit = (drn_q == DRN_LAST);

   // Drain counter sits at 0 while idle so it starts from 0 on the first DRAIN cycle.
   always_comb begin
      drn_d = drn_q;
      tmo_d = tmo_q;
      if (state_q == S_IDLE)
         drn_d = '0;
      else if (state_q == S_DRAIN && !tmo_hit)
         drn_d = drn_q + 1'b1;
      if (tmo_clr)
         tmo_d = 1'b0;
      else if (tmo_set)
         tmo_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drn_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         drn_q <= drn_d;
         tmo_q <= tmo_d;
      end
   end

   assign timeout_o = tmo_q;
`else
   logic [31:0] unused_drain_timeout;
   logic        unused_tmo;

   assign unused_drain_timeout = DRAIN_TIMEOUT;
   assign unused_tmo           = tmo_set ^ tmo_clr;
   assign tmo_hit              = 1'b0;
   assign timeout_o            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmo_set = 1'b0;
      tmo_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (trig_i) begin
               state_d = S_DRAIN;
               tmo_clr = 1'b1;
            end
         end
         S_DRAIN: begin
            // An empty counter wins over a coincident timeout: no flag in that case.
            if (cnt_q == '0 || tmo_hit) begin
               state_d = S_HOLD;
               hold_d  = '0;
               tmo_set = (cnt_q != '0);
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST)
               state_d = S_DONE;
            else
               hold_d = hold_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      block_d = (state_d != S_IDLE);
      rsto_d  = (state_d == S_HOLD);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_HOLD)
         cnt_d = '0;
      else if (issue_i && !done_i) begin
         if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
      end else if (done_i && !issue_i) begin
         if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         block_q <= 1'b0;
         rsto_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         block_q <= block_d;
         rsto_q  <= rsto_d;
      end
   end

   assign block_o   = block_q;
   assign rst_out_o = rsto_q;
endmodule

module vai_reset_seq #(
   parameter int NUM_SUB_AFUS  = 8,
   parameter int CNT_W         = 10,
   parameter int RESET_CYCLES  = 16,
   parameter int DRAIN_TIMEOUT = 256,
   parameter int VMID_W        = $clog2(NUM_SUB_AFUS)
) (
   input  logic                    pClk,
   input  logic                    pck_cp2af_softReset_n,
   input  logic [63:0]             sub_afu_reset,
   input  logic                    req_issue_valid,
   input  logic [VMID_W-1:0]       req_issue_vmid,
   input  logic                    rsp_done_valid,
   input  logic [VMID_W-1:0]       rsp_done_vmid,
   output logic [NUM_SUB_AFUS-1:0] sub_afu_block,
   output logic [NUM_SUB_AFUS-1:0] sub_afu_rst_out,
   output logic [63:0]             reset_status
);
   logic [NUM_SUB_AFUS-1:0] rst_q, trig, tmo;

   assign trig = sub_afu_reset[NUM_SUB_AFUS-1:0] & ~rst_q;

   always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n)
         rst_q <= '0;
      else
         rst_q <= sub_afu_reset[NUM_SUB_AFUS-1:0];
   end

   for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_lane
      vai_reset_seq_lane #(
         .CNT_W         (CNT_W),
         .RESET_CYCLES  (RESET_CYCLES),
         .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
      ) u_lane (
         .clk_i     (pClk),
         .rst_ni    (pck_cp2af_softReset_n),
         .trig_i    (trig[i]),
         .issue_i   (req_issue_valid && (req_issue_vmid == VMID_W'(i))),
         .done_i    (rsp_done_valid && (rsp_done_vmid == VMID_W'(i))),
         .block_o   (sub_afu_block[i]),
         .rst_out_o (sub_afu_rst_out[i]),
         .timeout_o (tmo[i])
      );
   end

   // Request bits above the populated sub-AFUs have no sequencer behind them.
   if (NUM_SUB_AFUS < 64) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^sub_afu_reset[63:NUM_SUB_AFUS];
   end

   // busy mirrors block: both mean "not IDLE".
   always_comb begin
      reset_status                     = '0;
      reset_status[NUM_SUB_AFUS-1:0]   = sub_afu_block;
      reset_status[32 +: NUM_SUB_AFUS] = tmo;
   end
endmodule

// File: tb/tb_vai_reset_seq.sv
// Scoreboard bench for vai_reset_seq: timestamp-based reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_vai_reset_seq;
   localparam int NUM  = 8;
   localparam int CW   = 10;
   localparam int RC   = 16;
   localparam int DT   = 256;
   localparam int VW   = 3;
   localparam int CMAX = (1 << CW) - 1;
`ifdef VAI_RESET_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           pClk  = 1'b0;
   logic           rst_n = 1'b0;
   logic [63:0]    sar   = '0;
   logic           iv    = 1'b0;
   logic [VW-1:0]  ivm   = '0;
   logic           dv    = 1'b0;
   logic [VW-1:0]  dvm   = '0;
   logic [NUM-1:0] d_blk, d_rso;
   logic [63:0]    d_stat;

   always #5 pClk = ~pClk;

   vai_reset_seq #(
      .NUM_SUB_AFUS (NUM), .CNT_W (CW), .RESET_CYCLES (RC), .DRAIN_TIMEOUT (DT), .VMID_W (VW)
   ) dut (
      .pClk                  (pClk),
      .pck_cp2af_softReset_n (rst_n),
      .sub_afu_reset         (sar),
      .req_issue_valid       (iv),
      .req_issue_vmid        (ivm),
      .rsp_done_valid        (dv),
      .rsp_done_vmid         (dvm),
      .sub_afu_block         (d_blk),
      .sub_afu_rst_out       (d_rso),
      .reset_status          (d_stat)
   );

   typedef struct packed {
      logic [NUM-1:0] blk;
      logic [NUM-1:0] rso;
      logic [63:0]    stat;
   } exp_t;

   exp_t exp_q[$];
   exp_t me;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: each sequence is described by the edge it was triggered on and the
   // edge its reset pulse began; all outputs are derived from those timestamps.
   int cnt[NUM];
   bit prev[NUM];
   bit act[NUM];
   int trig_at[NUM];
   int hold_at[NUM];
   bit tmo[NUM];
   int cyc = 0;

   function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s @%0t: got %h, expected %h", nm, $time, a, e);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM; i++) begin
         cnt[i] = 0; prev[i] = 1'b0; act[i] = 1'b0;
         trig_at[i] = 0; hold_at[i] = -1; tmo[i] = 1'b0;
      end
   endtask

   task automatic model_edge(output exp_t e);
      int n;
      bit in_hold, iss, dn;
      n = cyc + 1;
      cyc = n;
      e = '0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NUM; i++) begin
         in_hold = act[i] && hold_at[i] >= 0 && (n - 1) <= hold_at[i] + RC - 1;
         iss     = iv && (int'(ivm) == i);
         dn      = dv && (int'(dvm) == i);
         if (!act[i]) begin
            if (sar[i] && !prev[i]) begin
               act[i] = 1'b1; trig_at[i] = n; hold_at[i] = -1; tmo[i] = 1'b0;
            end
         end else if (hold_at[i] < 0) begin
            if (cnt[i] == 0)
               hold_at[i] = n;
            else if (TO_EN && (n - trig_at[i] == DT)) begin
               hold_at[i] = n; tmo[i] = 1'b1;
            end
         end else if (n == hold_at[i] + RC + 1)
            act[i] = 1'b0;
         if (in_hold)
            cnt[i] = 0;
         else if (iss && !dn)
            cnt[i] = (cnt[i] >= CMAX) ? CMAX : cnt[i] + 1;
         else if (dn && !iss && cnt[i] > 0)
            cnt[i] = cnt[i] - 1;
         prev[i] = sar[i];
         e.blk[i]       = act[i];
         e.rso[i]       = act[i] && hold_at[i] >= 0 && n <= hold_at[i] + RC - 1;
         e.stat[i]      = act[i];
         e.stat[32 + i] = tmo[i];
      end
   endtask

   task automatic step();
      exp_t e;
      model_edge(e);
      @(posedge pClk);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      iv = 1'b0; dv = 1'b0;
      repeat (n) step();
   endtask

   task automatic issue(input int vm, input int n);
      iv = 1'b1; ivm = VW'(vm);
      repeat (n) step();
      iv = 1'b0;
   endtask

   task automatic done(input int vm, input int n);
      dv = 1'b1; dvm = VW'(vm);
      repeat (n) step();
      dv = 1'b0;
   endtask

   // Reset asserted between edges: the entry already queued for this cycle becomes all-zero.
   task automatic async_reset();
      exp_t z;
      z = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      exp_q[exp_q.size() - 1] = z;
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge pClk);
         if (exp_q.size() != 0) begin
            me = exp_q.pop_front();
            chk("sub_afu_block", 64'(d_blk), 64'(me.blk));
            chk("sub_afu_rst_out", 64'(d_rso), 64'(me.rso));
            chk("reset_status", d_stat, me.stat);
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;
      idle(2);

      // single trigger, held request must not retrigger
      sar = 64'h4; step();
      repeat (24) step();
      sar = '0; idle(5);

      // drain waits for three outstanding completions
      issue(1, 3);
      sar = 64'h2; step();
      idle(50);
      done(1, 3);
      idle(25);

      // counter rules: same-cycle issue+done, underflow, saturation
      issue(0, 2);
      iv = 1'b1; ivm = 3'd0; dv = 1'b1; dvm = 3'd0; step();
      iv = 1'b0; dvm = 3'd5; step(); dv = 1'b0;
      issue(6, CMAX + 7);
      done(6, CMAX - 1);
      sar = 64'h41; step();
      idle(10);
      done(6, 1);
      done(0, 2);
      idle(25);

      // never-completed request: timeout path or indefinite drain
      issue(3, 1);
      sar = 64'h8; step();
      idle(300);
      done(3, 1);
      idle(25);
      sar = '0; step();
      sar = 64'h8; step();
      idle(25);

      // overlapping sequences, retrigger during HOLD ignored
      sar = 64'h1; step();
      sar = 64'h81; step();
      idle(5);
      sar = 64'h80; step();
      sar = 64'h81; step();
      idle(25);

      // async reset mid-sequence with counts outstanding
      sar = '0; step();
      issue(2, 4);
      sar = 64'h1F; step();
      idle(4);
      sar = '0;
      async_reset();
      idle(3);
      sar = 64'h4; step();
      idle(22);

      // randomized traffic, including high request bits and one mid-run reset
      for (int c = 0; c < 3000; c++) begin
         iv  = ($urandom_range(0, 1) == 0);
         ivm = VW'($urandom_range(0, NUM - 1));
         dv  = ($urandom_range(0, 2) != 0);
         dvm = VW'($urandom_range(0, NUM - 1));
         if ($urandom_range(0, 15) == 0)
            sar = {$urandom(), $urandom()};
         if (c == 1500)
            async_reset();
         else
            step();
      end
      sar = '0;
      idle(300);
      @(negedge pClk);
      @(negedge pClk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
